// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - scan codes, direction codes and decoder state shared by the PS/2 direction logic
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_UP    = 8'h75;
  localparam logic [7:0] PS2_RIGHT = 8'h74;
  localparam logic [7:0] PS2_DOWN  = 8'h72;
  localparam logic [7:0] PS2_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_W     = 8'h1D;
  localparam logic [7:0] PS2_D     = 8'h23;
  localparam logic [7:0] PS2_S     = 8'h1B;
  localparam logic [7:0] PS2_A     = 8'h1C;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_DOWN  = 3'd3;
  localparam logic [2:0] DIR_LEFT  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_state_e;

  // Held-bit vectors are ordered {left, down, right, up}.
  function automatic logic [3:0] arrow_onehot(input logic [7:0] code);
    case (code)
      PS2_UP:    arrow_onehot = 4'b0001;
      PS2_RIGHT: arrow_onehot = 4'b0010;
      PS2_DOWN:  arrow_onehot = 4'b0100;
      PS2_LEFT:  arrow_onehot = 4'b1000;
      default:   arrow_onehot = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] wasd_onehot(input logic [7:0] code);
    case (code)
      PS2_W:   wasd_onehot = 4'b0001;
      PS2_D:   wasd_onehot = 4'b0010;
      PS2_S:   wasd_onehot = 4'b0100;
      PS2_A:   wasd_onehot = 4'b1000;
      default: wasd_onehot = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ps2_dir_encode.sv
// rtl/ps2_dir_encode.sv - maps four direction levels to a direction code, 0 unless exactly one is high
module ps2_dir_encode
  import ps2_pkg::*;
(
  input  logic       up,
  input  logic       right,
  input  logic       down,
  input  logic       left,
  output logic [2:0] dir_code
);

  always_comb begin
    dir_code = DIR_NONE;
    case ({left, down, right, up})
      4'b0001: dir_code = DIR_UP;
      4'b0010: dir_code = DIR_RIGHT;
      4'b0100: dir_code = DIR_DOWN;
      4'b1000: dir_code = DIR_LEFT;
      default: dir_code = DIR_NONE;
    endcase
  end

endmodule

// File: rtl/ps2_direction_decoder.sv
// rtl/ps2_direction_decoder.sv - tracks make/break/extended PS/2 sequences into held direction levels
module ps2_direction_decoder
  import ps2_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 1000000,
  parameter bit ENABLE_WASD    = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_out,
  output logic       upSig,
  output logic       rightSig,
  output logic       downSig,
  output logic       leftSig,
  output logic [2:0] dir_code,
  output logic       key_event
);

  localparam int CNT_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       arrow_q, arrow_d;
  logic [3:0]       wasd_q, wasd_d;
  logic             key_event_q, key_event_d;
  logic [3:0]       arrow_hit;
  logic [3:0]       wasd_hit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    arrow_d     = arrow_q;
    wasd_d      = wasd_q;
    arrow_hit   = arrow_onehot(ps2_out);
    wasd_hit    = ENABLE_WASD ? wasd_onehot(ps2_out) : 4'b0000;

    if (ps2_key_pressed) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (ps2_out == PS2_EXT) begin
            state_d = ST_EXT;
          end else if (ps2_out == PS2_BRK) begin
            state_d = ST_BRK;
          end else begin
            wasd_d = wasd_q | wasd_hit;
          end
        end
        ST_EXT: begin
          if (ps2_out == PS2_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            arrow_d = arrow_q | arrow_hit;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          wasd_d  = wasd_q & ~wasd_hit;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          arrow_d = arrow_q & ~arrow_hit;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // An unfinished prefix is dropped once the byte that completes it is overdue.
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end

    key_event_d = ({arrow_d, wasd_d} != {arrow_q, wasd_q});
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      arrow_q     <= 4'b0000;
      wasd_q      <= 4'b0000;
      key_event_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      arrow_q     <= arrow_d;
      wasd_q      <= wasd_d;
      key_event_q <= key_event_d;
    end
  end

  assign upSig     = arrow_q[0] | wasd_q[0];
  assign rightSig  = arrow_q[1] | wasd_q[1];
  assign downSig   = arrow_q[2] | wasd_q[2];
  assign leftSig   = arrow_q[3] | wasd_q[3];
  assign key_event = key_event_q;

  ps2_dir_encode u_dir_encode (
    .up       (upSig),
    .right    (rightSig),
    .down     (downSig),
    .left     (leftSig),
    .dir_code (dir_code)
  );

endmodule
